// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one cache-line memory port between the I-cache and the D-cache.
// Only one transaction is in flight at a time. All outputs are registered, and each requester gets a one-cycle ready pulse.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic req_i, req_d;
    req_t win;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state: on a tie in IDLE, the requester that was not granted last time wins
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req_i && (!req_d || last_grant_q == GNT_D)) begin
                    state_d      = BUSY_I;
                    last_grant_d = GNT_I;
                end else if (req_d) begin
                    state_d      = BUSY_D;
                    last_grant_d = GNT_D;
                end
            end
            BUSY_I, BUSY_D: if (mem_ready) state_d = RELEASE;
            default:        state_d = IDLE;
        endcase
    end

    // Output next values; the winner's command is latched only on the grant edge
    always_comb begin
        win.rd    = i_read;
        win.wr    = i_write;
        win.addr  = i_addr;
        win.wdata = i_wdata;
        if (last_grant_d == GNT_D) begin
            win.rd    = d_read;
            win.wr    = d_write;
            win.addr  = d_addr;
            win.wdata = d_wdata;
        end
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (state_d != IDLE) begin
                    mem_write_d = win.wr;
                    mem_read_d  = win.rd & ~win.wr;
                    mem_addr_d  = win.addr;
                    mem_wdata_d = win.wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected commands/completions, a monitor pops and checks them.
// A small memory model answers each command after mem_lat cycles and holds mem_ready for mem_hold cycles.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] i_wdata = '0, d_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_ready, d_ready, mem_read, mem_write;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        bit            is_rdy;
        bit            src_d;
        bit            wr;
        bit            rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            req_cyc;
        bit            after_rdy;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] rd_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, mr_cyc = -100, last_rdy_cyc = -100, n_rdy = 0;
    int mem_lat = 5, mem_hold = 1;
    int stray_req = 0, stray_done = 0;
    int i_left = 0, d_left = 0;

    localparam logic [DW-1:0] R1 = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void exp_cmd(bit d, bit wr, bit rd, logic [AW-1:0] a, logic [DW-1:0] w,
                                    int rc, bit ar);
        exp_t e;
        e.is_rdy = 1'b0; e.src_d = d; e.wr = wr; e.rd = rd; e.addr = a; e.data = w;
        e.req_cyc = rc; e.after_rdy = ar;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_rdy(bit d, logic [DW-1:0] r);
        exp_t e;
        e.is_rdy = 1'b1; e.src_d = d; e.wr = 1'b0; e.rd = 1'b0; e.addr = '0; e.data = r;
        e.req_cyc = -1; e.after_rdy = 1'b0;
        exp_q.push_back(e);
        rd_q.push_back(r);
    endfunction

    // Memory model
    initial begin : mem_model
        int wait_left;
        int hold_left;
        wait_left = -1;
        hold_left = 0;
        forever begin
            @(negedge clk);
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) mem_ready = 1'b0;
            end else if (!(mem_read || mem_write)) begin
                wait_left = -1;
                if (stray_req != stray_done) begin
                    stray_done = stray_req;
                    mem_ready  = 1'b1;
                    hold_left  = 1;
                end
            end else begin
                if (wait_left < 0) wait_left = mem_lat;
                else if (wait_left > 0) wait_left--;
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : '0;
                    mr_cyc    = cyc;
                    hold_left = mem_hold;
                    wait_left = -1;
                end
            end
        end
    end

    // Monitor
    initial begin : monitor
        exp_t          e;
        logic          prev;
        logic          s_rd, s_wr;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        prev = 1'b0;
        s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
        forever begin
            @(negedge clk);
            if ((mem_read === 1'b1 || mem_write === 1'b1) && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got rd=%b wr=%b addr=%h want none", mem_read, mem_write, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chki("cmd_kind", int'(e.is_rdy), 0);
                    chk("cmd_write", DW'(mem_write), DW'(e.wr));
                    chk("cmd_read", DW'(mem_read), DW'(e.rd));
                    chk("cmd_addr", DW'(mem_addr), DW'(e.addr));
                    chk("cmd_wdata", mem_wdata, e.data);
                    if (e.req_cyc >= 0) chki("grant_latency", cyc - e.req_cyc, 1);
                    if (e.after_rdy) chki("turnaround", cyc - last_rdy_cyc, 2);
                end
                s_rd = mem_read; s_wr = mem_write; s_addr = mem_addr; s_wdata = mem_wdata;
            end else if ((mem_read === 1'b1 || mem_write === 1'b1) && prev) begin
                chki("cmd_hold", int'(mem_read === s_rd && mem_write === s_wr &&
                                      mem_addr === s_addr && mem_wdata === s_wdata), 1);
            end
            if (i_ready === 1'b1 || d_ready === 1'b1) begin
                n_rdy++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: got i=%b d=%b want none", i_ready, d_ready);
                end else begin
                    e = exp_q.pop_front();
                    chki("rdy_kind", int'(e.is_rdy), 1);
                    chk("rdy_src", DW'(d_ready), DW'(e.src_d));
                    chk("rdy_excl", DW'(i_ready & d_ready), '0);
                    chk("rdata", e.src_d ? d_rdata : i_rdata, e.data);
                    chki("rdy_latency", cyc - mr_cyc, 1);
                    chk("cmd_off_at_rdy", DW'(mem_read | mem_write), '0);
                end
                last_rdy_cyc = cyc;
            end
            prev = (mem_read === 1'b1 || mem_write === 1'b1);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_mem_read"}, DW'(mem_read), '0);
        chk({tag, "_mem_write"}, DW'(mem_write), '0);
        chk({tag, "_mem_addr"}, DW'(mem_addr), '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_i_ready"}, DW'(i_ready), '0);
        chk({tag, "_d_ready"}, DW'(d_ready), '0);
        chk({tag, "_i_rdata"}, i_rdata, '0);
        chk({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive requesters: on each ready, reissue with the next address until the count runs out
    task automatic run_reqs(input int bound);
        int n;
        n = 0;
        while ((i_left > 0 || d_left > 0) && n < bound) begin
            @(negedge clk);
            n++;
            if (i_ready === 1'b1 && i_left > 0) begin
                i_left--;
                if (i_left == 0) begin i_read = 1'b0; i_write = 1'b0; end
                else i_addr = i_addr + 1'b1;
            end
            if (d_ready === 1'b1 && d_left > 0) begin
                d_left--;
                if (d_left == 0) begin d_read = 1'b0; d_write = 1'b0; end
                else begin d_addr = d_addr + 1'b1; d_wdata = d_wdata + 1'b1; end
            end
        end
        if (i_left > 0 || d_left > 0) begin
            checks++; errors++;
            $display("FAIL completion_timeout: got i_left=%0d d_left=%0d want 0 0", i_left, d_left);
            i_left = 0; d_left = 0;
            i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        int n0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single I read, memory answers 5 cycles after the command
        mem_lat = 5; mem_hold = 1;
        i_addr = 28'h0000040; i_wdata = '0; i_read = 1'b1; i_left = 1;
        exp_cmd(1'b0, 1'b0, 1'b1, 28'h0000040, '0, cyc, 1'b0);
        exp_rdy(1'b0, R1);
        run_reqs(50);

        // Simultaneous I read and D write after reset: D first, I exactly 3 cycles after D's mem_ready
        do_reset();
        mem_lat = 2;
        i_addr = 28'h0000100; i_read = 1'b1; i_left = 1;
        d_addr = 28'h0000200; d_wdata = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
        d_write = 1'b1; d_left = 1;
        exp_cmd(1'b1, 1'b1, 1'b0, 28'h0000200, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D, cyc, 1'b0);
        exp_rdy(1'b1, 128'h2222);
        exp_cmd(1'b0, 1'b0, 1'b1, 28'h0000100, '0, -1, 1'b1);
        exp_rdy(1'b0, 128'h3333);
        run_reqs(60);

        // Fairness: both reassert immediately, grant order D I D I D I
        do_reset();
        mem_lat = 1;
        i_addr = 28'h0001000; i_read = 1'b1; i_left = 3;
        d_addr = 28'h0002000; d_wdata = 128'h5000; d_write = 1'b1; d_left = 3;
        for (int k = 0; k < 3; k++) begin
            exp_cmd(1'b1, 1'b1, 1'b0, 28'h0002000 + AW'(k), 128'h5000 + DW'(k), (k == 0) ? cyc : -1, k != 0);
            exp_rdy(1'b1, 128'hD000_0000 + DW'(k));
            exp_cmd(1'b0, 1'b0, 1'b1, 28'h0001000 + AW'(k), '0, -1, 1'b1);
            exp_rdy(1'b0, 128'h1000_0000 + DW'(k));
        end
        run_reqs(200);

        // Illegal read+write from D: write wins
        d_addr = 28'h0003030; d_wdata = 128'h7777; d_read = 1'b1; d_write = 1'b1; d_left = 1;
        exp_cmd(1'b1, 1'b1, 1'b0, 28'h0003030, 128'h7777, cyc, 1'b0);
        exp_rdy(1'b1, 128'h8888);
        run_reqs(50);

        // Stray mem_ready in IDLE, then mem_ready held 3 cycles during BUSY_D
        n0 = n_rdy;
        stray_req++;
        repeat (4) @(negedge clk);
        chki("stray_ready_pulses", n_rdy - n0, 0);
        mem_hold = 3; mem_lat = 2;
        d_addr = 28'h0004000; d_wdata = 128'h9; d_read = 1'b1; d_left = 1;
        exp_cmd(1'b1, 1'b0, 1'b1, 28'h0004000, 128'h9, cyc, 1'b0);
        exp_rdy(1'b1, 128'hAAAA);
        n0 = n_rdy;
        run_reqs(50);
        repeat (3) @(negedge clk);
        chki("held_ready_pulses", n_rdy - n0, 1);
        mem_hold = 1;

        // Reset 2 cycles after mem_read rises in BUSY_I; afterwards D wins the tie
        mem_lat = 20;
        i_addr = 28'h0005000; i_read = 1'b1;
        exp_cmd(1'b0, 1'b0, 1'b1, 28'h0005000, '0, cyc, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        d_addr = 28'h0006000; d_wdata = 128'h66; d_read = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        mem_lat = 2;
        i_left = 1; d_left = 1;
        exp_cmd(1'b1, 1'b0, 1'b1, 28'h0006000, 128'h66, cyc, 1'b0);
        exp_rdy(1'b1, 128'hBBBB);
        exp_cmd(1'b0, 1'b0, 1'b1, 28'h0005000, '0, -1, 1'b1);
        exp_rdy(1'b0, 128'hCCCC);
        run_reqs(80);

        chki("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
